// File: rtl/sink_serializer_pkg.sv
// sink_serializer_pkg: configuration packages for the sink serializer.
//   sink_config       - width of the network_sink output word.
//   serializer_config - derived byte count / pad / index width, FSM state
//                       type and padded frame type for the default width.
package sink_config;
  localparam int NET_NUM_OUT = 12;
  localparam int SNK_WIDTH = NET_NUM_OUT;
endpackage

package serializer_config;
  import sink_config::*;
  function automatic int ser_bytes(input int w);
    return (w + 7) / 8;
  endfunction
  localparam int SER_BYTES = ser_bytes(SNK_WIDTH);
  localparam int SER_PAD = 8 * SER_BYTES - SNK_WIDTH;
  localparam int SER_IDX_WIDTH = $clog2(SER_BYTES + 1);
  typedef enum logic [1:0] {IDLE, HDR, SEND} ser_state_t;
  typedef logic [8*SER_BYTES-1:0] ser_frame_t;
endpackage

// File: rtl/sink_serializer.sv
// sink_serializer: splits each SNK_WIDTH-bit word into bytes, MSB first,
// zero-padded at the top to a byte boundary.
// Ports:
//   clk, arstn            - clock, asynchronous active-low reset
//   snk_valid/snk_ready   - word handshake from network_sink, snk = word
//   tx_valid/tx_ready     - byte handshake toward the host link, tx_data = byte
//   busy                  - a frame is in progress
// Optional: define SINK_SERIALIZER_SEQ_TAG_EN to prefix every frame with an
// 8-bit sequence count that advances after each completed frame.
module sink_serializer
  import serializer_config::*;
#(
  parameter int SNK_WIDTH = sink_config::SNK_WIDTH,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic [SNK_WIDTH-1:0]  snk,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  busy
);
  localparam int NB = ser_bytes(SNK_WIDTH);
  localparam int FW = BYTE_WIDTH * NB;
  localparam int IW = $clog2(NB + 1);
  if (BYTE_WIDTH != 8 || SNK_WIDTH < 1) begin : g_bad_cfg
    $error("sink_serializer: BYTE_WIDTH must be 8 and SNK_WIDTH at least 1");
  end
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
  localparam ser_state_t FIRST = HDR;
`else
  localparam ser_state_t FIRST = SEND;
`endif
  ser_state_t r_state, w_next;
  logic [FW-1:0] r_shift;
  logic [BYTE_WIDTH-1:0] r_tx_data;
  logic [IW-1:0] r_idx;
  logic [FW-1:0] w_frame;
  logic w_snk_hs, w_tx_hs, w_last;
  // Zero-extension puts the pad bits above the word.
  assign w_frame = FW'(snk);
  assign w_snk_hs = snk_valid & snk_ready;
  assign w_tx_hs = tx_valid & tx_ready;
  assign w_last = r_idx == IW'(NB - 1);
  assign tx_data = r_tx_data;
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = w_snk_hs ? FIRST : IDLE;
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
      HDR: w_next = w_tx_hs ? SEND : HDR;
`endif
      SEND: w_next = (w_tx_hs && w_last) ? IDLE : SEND;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    snk_ready = r_state == IDLE;
    tx_valid = r_state != IDLE;
    busy = r_state != IDLE;
  end
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
  logic [7:0] r_seq;
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) r_seq <= '0;
    else if (r_state == SEND && w_tx_hs && w_last) r_seq <= r_seq + 8'd1;
`endif
  // r_shift always holds the not-yet-presented bytes at its top; tx_data is
  // reloaded from it on every accepted byte except the final one.
  always_ff @(posedge clk or negedge arstn)
    if (!arstn) begin
      r_tx_data <= '0;
      r_shift <= '0;
      r_idx <= '0;
    end else if (r_state == IDLE && w_snk_hs) begin
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
      r_tx_data <= r_seq;
      r_shift <= w_frame;
`else
      r_tx_data <= w_frame[FW-1 -: BYTE_WIDTH];
      r_shift <= w_frame << BYTE_WIDTH;
`endif
      r_idx <= '0;
    end else if (w_tx_hs && !(r_state == SEND && w_last)) begin
      r_tx_data <= r_shift[FW-1 -: BYTE_WIDTH];
      r_shift <= r_shift << BYTE_WIDTH;
      if (r_state == SEND) r_idx <= r_idx + 1'b1;
    end
endmodule

// File: tb/tb_sink_serializer.sv
// tb_sink_serializer: four serializers of widths 12, 16, 5 and 24 under random
// traffic, each compared every cycle against a frame-level byte model.
module tb_sink_serializer;
  localparam int W [4] = '{12, 16, 5, 24};
  logic clk, arstn;
  logic [3:0] snk_valid, snk_ready, tx_valid, tx_ready, busy;
  logic [23:0] snk [4];
  logic [7:0] tx_data [4];
  int n_pass = 0, n_total = 0;
  bit checking = 0, mode = 0;
  bit [3:0] pin = '0;
  int m_busy [4], m_n [4], m_k [4], m_seq [4];
  int m_b [4][4];
  logic [23:0] lit_word [4] = '{24'hABC, 24'h1234, 24'hF6, 24'h00FF00};
  int lit_n [4] = '{2, 2, 1, 3};
  int lit_b [4][3] = '{'{'h0A, 'hBC, 0}, '{'h12, 'h34, 0}, '{'h16, 0, 0}, '{'h00, 'hFF, 'h00}};
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  sink_serializer #(.SNK_WIDTH(12)) u0 (.clk(clk), .arstn(arstn), .snk_valid(snk_valid[0]), .snk_ready(snk_ready[0]),
    .snk(snk[0][11:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .busy(busy[0]));
  sink_serializer #(.SNK_WIDTH(16)) u1 (.clk(clk), .arstn(arstn), .snk_valid(snk_valid[1]), .snk_ready(snk_ready[1]),
    .snk(snk[1][15:0]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .busy(busy[1]));
  sink_serializer #(.SNK_WIDTH(5)) u2 (.clk(clk), .arstn(arstn), .snk_valid(snk_valid[2]), .snk_ready(snk_ready[2]),
    .snk(snk[2][4:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .tx_data(tx_data[2]), .busy(busy[2]));
  sink_serializer #(.SNK_WIDTH(24)) u3 (.clk(clk), .arstn(arstn), .snk_valid(snk_valid[3]), .snk_ready(snk_ready[3]),
    .snk(snk[3]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]), .tx_data(tx_data[3]), .busy(busy[3]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[dut%0d] at %0t: got 'h%0h expected 'h%0h", nm, d, $time, act, exp);
  endtask

  // Frame model: optional tag, then ceil(W/8) bytes of the zero-extended word, MSB first.
  task automatic accept(input int d);
    longint val = longint'(snk[d]) & ((64'd1 << W[d]) - 1);
    int sb = (W[d] + 7) / 8;
    int n = 0;
`ifdef SINK_SERIALIZER_SEQ_TAG_EN
    m_b[d][n++] = m_seq[d];
`endif
    for (int k = 0; k < sb; k++) m_b[d][n++] = int'((val >> (8 * (sb - 1 - k))) & 64'hFF);
    m_n[d] = n;
    m_k[d] = 0;
    m_busy[d] = 1;
    if (pin[d]) begin
      pin[d] = 0;
      chk("lit_len", d, m_n[d], lit_n[d] + OFF);
      for (int k = 0; k < lit_n[d]; k++) chk("lit_byte", d, m_b[d][OFF + k], lit_b[d][k]);
    end
  endtask

  always @(posedge clk or negedge arstn) begin
    for (int d = 0; d < 4; d++)
      if (!arstn) begin
        m_busy[d] = 0; m_k[d] = 0; m_n[d] = 0; m_seq[d] = 0;
      end else if (!m_busy[d]) begin
        if (snk_valid[d]) accept(d);
      end else if (tx_ready[d]) begin
        m_k[d]++;
        if (m_k[d] == m_n[d]) begin
          m_busy[d] = 0;
          m_k[d] = 0;
          m_seq[d] = (m_seq[d] + 1) % 256;
        end
      end
  end

  always @(negedge clk) begin
    if (checking && arstn)
      for (int d = 0; d < 4; d++) begin
        chk("snk_ready", d, snk_ready[d], m_busy[d] == 0);
        chk("busy", d, busy[d], m_busy[d]);
        chk("tx_valid", d, tx_valid[d], m_busy[d]);
        if (m_busy[d] != 0) chk("tx_data", d, tx_data[d], m_b[d][m_k[d]]);
      end
    for (int d = 0; d < 4; d++)
      if (mode) begin
        snk_valid[d] = 1; snk[d] = lit_word[d]; tx_ready[d] = 1;
      end else begin
        snk_valid[d] = ($urandom % 3) != 0;
        snk[d] = 24'($urandom);
        tx_ready[d] = ($urandom % 4) != 0;
      end
  end

  initial begin
    int waited;
    arstn = 1;
    snk_valid = '0; tx_ready = '0;
    for (int d = 0; d < 4; d++) snk[d] = '0;
    #1 arstn = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_tx_valid", d, tx_valid[d], 0);
      chk("rst_busy", d, busy[d], 0);
      chk("rst_tx_data", d, tx_data[d], 0);
    end
    #21 arstn = 1;
    #1;
    for (int d = 0; d < 4; d++) chk("post_rst_snk_ready", d, snk_ready[d], 1);
    checking = 1;
    repeat (3000) @(negedge clk);
    waited = 0;
    while (!(m_busy[3] != 0 && m_k[3] == 1) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("midframe_reached", 3, waited < 500, 1);
    #1 checking = 0;
    arstn = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("mid_rst_tx_valid", d, tx_valid[d], 0);
      chk("mid_rst_busy", d, busy[d], 0);
      chk("mid_rst_tx_data", d, tx_data[d], 0);
    end
    mode = 1;
    pin = '1;
    @(posedge clk);
    @(negedge clk);
    #1 arstn = 1;
    checking = 1;
    repeat (20) @(negedge clk);
    mode = 0;
    chk("pins_taken", 0, pin, 0);
    repeat (1000) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
